// File: rtl/cmp_loader_pkg.sv
// Shared types and constant functions for the partial-product column loader.
package cmp_loader_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WAIT_W = 8;

    function automatic int unsigned min2(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    // Column i of a wa x wb array holds min(i+1, wa, wb, cols-i) partial-product bits.
    function automatic int unsigned col_height(input int unsigned i,
                                               input int unsigned wa,
                                               input int unsigned wb);
        int unsigned cols;
        int unsigned h;
        cols = wa + wb - 1;
        h    = i + 1;
        h    = min2(h, wa);
        h    = min2(h, wb);
        h    = min2(h, cols - i);
        return h;
    endfunction

    function automatic int unsigned col_offset(input int unsigned i,
                                               input int unsigned wa,
                                               input int unsigned wb);
        int unsigned s;
        s = 0;
        for (int unsigned j = 0; j < i; j++) begin
            s += col_height(j, wa, wb);
        end
        return s;
    endfunction

    function automatic int unsigned total_bits(input int unsigned wa, input int unsigned wb);
        return wa * wb;
    endfunction

endpackage

// File: rtl/cmp_column_loader_if.sv
// Handshake and data bundle between the bit source, the loader and the compressor.
interface cmp_column_loader_if #(
    parameter int unsigned COLS  = 45,
    parameter int unsigned TOTAL = 529
);
    logic             in_valid;
    logic             in_ready;
    logic [COLS-1:0]  in_bits;
    logic             cols_valid;
    logic [TOTAL-1:0] col_bus;
    logic [COLS:0]    res_in;
    logic             out_valid;
    logic             out_ready;
    logic [COLS:0]    res_out;

    modport master (
        output in_valid, in_bits, res_in, out_ready,
        input  in_ready, cols_valid, col_bus, out_valid, res_out
    );

    modport slave (
        input  in_valid, in_bits, res_in, out_ready,
        output in_ready, cols_valid, col_bus, out_valid, res_out
    );
endinterface

// File: rtl/cmp_column_sreg.sv
// One compressor column: H-bit left shift register, new bit enters at bit 0.
module cmp_column_sreg #(
    parameter int unsigned H = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift,
    input  logic         clear,
    input  logic         din,
    output logic [H-1:0] q
);

    // The oldest bit (position H-1) falls off the top on every shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (shift) begin
            q <= H'({q, din});
        end
    end

endmodule

// File: rtl/cmp_column_loader.sv
// Serially fills the compressor column registers, waits out the compressor
// pipeline and captures its result behind a valid/ready handshake.
module cmp_column_loader
    import cmp_loader_pkg::*;
#(
    parameter int unsigned W_A           = 23,
    parameter int unsigned W_B           = 23,
    parameter int unsigned PIPE_LAT      = 0,
    parameter int unsigned CLEAR_ON_DONE = 1
) (
    input  logic                clk,
    input  logic                rst,
    cmp_column_loader_if.slave  bus
);

    localparam int unsigned COLS  = W_A + W_B - 1;
    localparam int unsigned MAX_H = min2(W_A, W_B);
    localparam int unsigned TOTAL = total_bits(W_A, W_B);
    localparam int unsigned CNT_W = $clog2(MAX_H + 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     beat_nxt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [WAIT_W-1:0]    wait_nxt;
    logic                 shift_c;
    logic                 clear_c;
    logic                 capture_c;

    logic                 in_ready_q;
    logic                 cols_valid_q;
    logic                 out_valid_q;
    logic [COLS:0]        res_q;
    logic [TOTAL-1:0]     col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        wait_nxt  = wait_cnt;
        shift_c   = 1'b0;
        clear_c   = 1'b0;
        capture_c = 1'b0;
        unique case (state)
            LOAD: begin
                wait_nxt = '0;
                if (bus.in_valid && in_ready_q) begin
                    shift_c = 1'b1;
                    if (beat_cnt == CNT_W'(MAX_H - 1)) begin
                        beat_nxt  = '0;
                        state_nxt = EVAL;
                    end else begin
                        beat_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            EVAL: begin
                if (wait_cnt == WAIT_W'(PIPE_LAT)) begin
                    capture_c = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = DONE;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    clear_c   = (CLEAR_ON_DONE != 0);
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Handshake flags follow the next state so they line up with it after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q   <= 1'b1;
            cols_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            res_q        <= '0;
        end else begin
            in_ready_q   <= (state_nxt == LOAD);
            cols_valid_q <= (state_nxt != LOAD);
            out_valid_q  <= (state_nxt == DONE);
            if (capture_c) begin
                res_q <= bus.res_in;
            end
        end
    end

    for (genvar i = 0; i < COLS; i++) begin : g_col
        localparam int unsigned H   = col_height(i, W_A, W_B);
        localparam int unsigned OFF = col_offset(i, W_A, W_B);

        cmp_column_sreg #(.H(H)) u_col (
            .clk   (clk),
            .rst   (rst),
            .shift (shift_c),
            .clear (clear_c),
            .din   (bus.in_bits[i]),
            .q     (col_q[OFF+H-1:OFF])
        );
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.cols_valid = cols_valid_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.res_out    = res_q;
    assign bus.col_bus    = col_q;

endmodule

// File: tb/tb_cmp_column_loader.sv
// Directed bench: three 4x4 loaders (latency 0 / 3 / no-clear) and one default 23x23.
module tb_cmp_column_loader;

    logic clk;
    logic rst;

    int checks;
    int passed;

    // 4x4 instances: 0 = PIPE_LAT 0 clear, 1 = PIPE_LAT 3 clear, 2 = PIPE_LAT 0 keep.
    logic [2:0] v4;
    logic [2:0] ord4;
    logic [6:0] b4 [3];
    logic [7:0] r4 [3];
    logic       rdy4 [3];
    logic       cv4 [3];
    logic       ov4 [3];
    logic [15:0] bus4 [3];
    logic [7:0] res4 [3];

    logic [15:0] t16;
    logic [6:0]  fb [4];

    for (genvar g = 0; g < 3; g++) begin : g_dut4
        cmp_column_loader_if #(.COLS(7), .TOTAL(16)) bi ();

        cmp_column_loader #(
            .W_A           (4),
            .W_B           (4),
            .PIPE_LAT      ((g == 1) ? 3 : 0),
            .CLEAR_ON_DONE ((g == 2) ? 0 : 1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bi.slave)
        );

        assign bi.in_valid  = v4[g];
        assign bi.in_bits   = b4[g];
        assign bi.res_in    = r4[g];
        assign bi.out_ready = ord4[g];
        assign rdy4[g]      = bi.in_ready;
        assign cv4[g]       = bi.cols_valid;
        assign ov4[g]       = bi.out_valid;
        assign bus4[g]      = bi.col_bus;
        assign res4[g]      = bi.res_out;
    end

    cmp_column_loader_if #(.COLS(45), .TOTAL(529)) b23 ();

    cmp_column_loader u_dut23 (
        .clk (clk),
        .rst (rst),
        .bus (b23.slave)
    );

    logic [44:0]  v23_bits;
    logic         v23;
    logic [45:0]  r23;
    logic         ord23;
    logic [528:0] all_ones;

    assign b23.in_valid  = v23;
    assign b23.in_bits   = v23_bits;
    assign b23.res_in    = r23;
    assign b23.out_ready = ord23;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int k, input logic [6:0] b);
        v4[k] = 1'b1;
        b4[k] = b;
        step();
        v4[k] = 1'b0;
        b4[k] = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            checks++; if (rdy4[k] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b want 1", k, rdy4[k]); else passed++;
            checks++; if (cv4[k] !== 1'b0) $display("FAIL reset_cols_valid[%0d]: got %b want 0", k, cv4[k]); else passed++;
            checks++; if (ov4[k] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov4[k]); else passed++;
            checks++; if (bus4[k] !== 16'h0000) $display("FAIL reset_col_bus[%0d]: got %h want 0000", k, bus4[k]); else passed++;
        end
        checks++; if (b23.res_out !== 46'h0) $display("FAIL reset_res_out23: got %h want 0", b23.res_out); else passed++;
        rst = 1'b0;

        // Abort a partial load on 0 and an in-progress wait on 1.
        beat(0, 7'h7F);
        beat(0, 7'h7F);
        for (int i = 0; i < 4; i++) beat(1, 7'h7F);
        step();
        checks++; if (cv4[1] !== 1'b1) $display("FAIL midwait_cols_valid: got %b want 1", cv4[1]); else passed++;
        rst = 1'b1;
        repeat (3) step();
        checks++; if (bus4[0] !== 16'h0000) $display("FAIL midload_rst_bus: got %h want 0000", bus4[0]); else passed++;
        checks++; if (rdy4[1] !== 1'b1) $display("FAIL midwait_rst_in_ready: got %b want 1", rdy4[1]); else passed++;
        rst = 1'b0;
        repeat (5) step();
        checks++; if (ov4[1] !== 1'b0) $display("FAIL abort_no_result_ov: got %b want 0", ov4[1]); else passed++;
        checks++; if (cv4[1] !== 1'b0) $display("FAIL abort_no_result_cv: got %b want 0", cv4[1]); else passed++;
        checks++; if (res4[1] !== 8'h00) $display("FAIL abort_res_out: got %h want 00", res4[1]); else passed++;
    endtask

    task automatic test_fill_order;
        r4[0] = 8'h3C;
        beat(0, 7'h7F);
        beat(0, 7'h00);
        beat(0, 7'h00);
        checks++; if (cv4[0] !== 1'b0) $display("FAIL fill_cv_after3: got %b want 0", cv4[0]); else passed++;
        beat(0, 7'h00);
        checks++; if (cv4[0] !== 1'b1) $display("FAIL fill_cv_after4: got %b want 1", cv4[0]); else passed++;
        checks++; if (rdy4[0] !== 1'b0) $display("FAIL fill_in_ready_eval: got %b want 0", rdy4[0]); else passed++;
        checks++; if (ov4[0] !== 1'b0) $display("FAIL fill_ov_eval: got %b want 0", ov4[0]); else passed++;
        t16 = bus4[0];
        checks++; if (t16[9:6] !== 4'b1000) $display("FAIL fill_col3: got %b want 1000", t16[9:6]); else passed++;
        checks++; if (t16 !== 16'h0200) $display("FAIL fill_col_bus: got %h want 0200", t16); else passed++;
        step();
        checks++; if (ov4[0] !== 1'b1) $display("FAIL fill_ov_done: got %b want 1", ov4[0]); else passed++;
        checks++; if (res4[0] !== 8'h3C) $display("FAIL fill_res_out: got %h want 3c", res4[0]); else passed++;
        r4[0] = 8'hC3;
        repeat (3) step();
        checks++; if (res4[0] !== 8'h3C) $display("FAIL fill_res_hold: got %h want 3c", res4[0]); else passed++;
        ord4[0] = 1'b1;
        step();
        ord4[0] = 1'b0;
        checks++; if (ov4[0] !== 1'b0) $display("FAIL fill_consume_ov: got %b want 0", ov4[0]); else passed++;
        checks++; if (cv4[0] !== 1'b0) $display("FAIL fill_consume_cv: got %b want 0", cv4[0]); else passed++;
        checks++; if (bus4[0] !== 16'h0000) $display("FAIL fill_clear_bus: got %h want 0000", bus4[0]); else passed++;
    endtask

    task automatic test_flow_control;
        fb[0] = 7'h40;
        fb[1] = 7'h00;
        fb[2] = 7'h00;
        fb[3] = 7'h01;
        for (int i = 0; i < 7; i++) begin
            v4[0] = (i % 2 == 0);
            b4[0] = (i % 2 == 0) ? fb[i / 2] : 7'h7F;
            step();
            if (i == 5) begin
                checks++; if (cv4[0] !== 1'b0) $display("FAIL toggle_cv_after3: got %b want 0", cv4[0]); else passed++;
            end
            if (i == 6) begin
                checks++; if (cv4[0] !== 1'b1) $display("FAIL toggle_cv_after4: got %b want 1", cv4[0]); else passed++;
                checks++; if (bus4[0] !== 16'h0001) $display("FAIL toggle_col_bus: got %h want 0001", bus4[0]); else passed++;
            end
        end
        v4[0] = 1'b1;
        b4[0] = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus4[0] !== 16'h0001) $display("FAIL frozen_bus[%0d]: got %h want 0001", i, bus4[0]); else passed++;
        end
        checks++; if (rdy4[0] !== 1'b0) $display("FAIL frozen_in_ready: got %b want 0", rdy4[0]); else passed++;
        checks++; if (ov4[0] !== 1'b1) $display("FAIL frozen_ov: got %b want 1", ov4[0]); else passed++;
        v4[0] = 1'b0;
        b4[0] = '0;
        ord4[0] = 1'b1;
        step();
        ord4[0] = 1'b0;
        checks++; if (bus4[0] !== 16'h0000) $display("FAIL toggle_clear_bus: got %h want 0000", bus4[0]); else passed++;
        checks++; if (rdy4[0] !== 1'b1) $display("FAIL toggle_back_to_load: got %b want 1", rdy4[0]); else passed++;
    endtask

    task automatic test_latency;
        r4[1] = 8'h00;
        for (int i = 0; i < 4; i++) beat(1, 7'h7F);
        checks++; if (cv4[1] !== 1'b1) $display("FAIL lat_cv: got %b want 1", cv4[1]); else passed++;
        checks++; if (ov4[1] !== 1'b0) $display("FAIL lat_ov_edge1: got %b want 0", ov4[1]); else passed++;
        repeat (3) step();
        checks++; if (ov4[1] !== 1'b0) $display("FAIL lat_ov_edge4: got %b want 0", ov4[1]); else passed++;
        r4[1] = 8'hA5;
        step();
        r4[1] = 8'h00;
        checks++; if (ov4[1] !== 1'b1) $display("FAIL lat_ov_edge5: got %b want 1", ov4[1]); else passed++;
        checks++; if (res4[1] !== 8'hA5) $display("FAIL lat_res_out: got %h want a5", res4[1]); else passed++;
        checks++; if (bus4[1] !== 16'hFFFF) $display("FAIL lat_col_bus: got %h want ffff", bus4[1]); else passed++;
    endtask

    task automatic test_backpressure;
        r4[1] = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (res4[1] !== 8'hA5 || ov4[1] !== 1'b1)
                $display("FAIL bp_hold[%0d]: got ov=%b res=%h want ov=1 res=a5", i, ov4[1], res4[1]); else passed++;
        end
        ord4[1] = 1'b1;
        step();
        ord4[1] = 1'b0;
        checks++; if (ov4[1] !== 1'b0) $display("FAIL bp_release_ov: got %b want 0", ov4[1]); else passed++;
        checks++; if (rdy4[1] !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", rdy4[1]); else passed++;
        checks++; if (cv4[1] !== 1'b0) $display("FAIL bp_release_cv: got %b want 0", cv4[1]); else passed++;
        checks++; if (bus4[1] !== 16'h0000) $display("FAIL bp_clear_bus: got %h want 0000", bus4[1]); else passed++;
    endtask

    task automatic test_no_clear;
        for (int i = 0; i < 4; i++) beat(2, 7'h7F);
        step();
        checks++; if (ov4[2] !== 1'b1) $display("FAIL keep_ov: got %b want 1", ov4[2]); else passed++;
        ord4[2] = 1'b1;
        step();
        ord4[2] = 1'b0;
        checks++; if (rdy4[2] !== 1'b1) $display("FAIL keep_in_ready: got %b want 1", rdy4[2]); else passed++;
        checks++; if (cv4[2] !== 1'b0) $display("FAIL keep_cv: got %b want 0", cv4[2]); else passed++;
        checks++; if (bus4[2] !== 16'hFFFF) $display("FAIL keep_retained_bus: got %h want ffff", bus4[2]); else passed++;
        beat(2, 7'h00);
        checks++; if (bus4[2] !== 16'h5BB4) $display("FAIL keep_shift_over: got %h want 5bb4", bus4[2]); else passed++;
    endtask

    task automatic test_default_23;
        r23 = 46'h2AAA_AAAA_AAAA;
        for (int i = 0; i < 22; i++) begin
            v23 = 1'b1;
            v23_bits = '1;
            step();
        end
        checks++; if (b23.cols_valid !== 1'b0) $display("FAIL d23_cv_after22: got %b want 0", b23.cols_valid); else passed++;
        step();
        v23 = 1'b0;
        v23_bits = '0;
        checks++; if (b23.cols_valid !== 1'b1) $display("FAIL d23_cv_after23: got %b want 1", b23.cols_valid); else passed++;
        checks++; if (b23.col_bus !== all_ones) $display("FAIL d23_col_bus_all_ones: got %h", b23.col_bus); else passed++;
        checks++; if (b23.col_bus[275:253] !== 23'h7FFFFF) $display("FAIL d23_col22: got %h want 7fffff", b23.col_bus[275:253]); else passed++;
        checks++; if (b23.col_bus[528] !== 1'b1) $display("FAIL d23_col44: got %b want 1", b23.col_bus[528]); else passed++;
        step();
        checks++; if (b23.out_valid !== 1'b1) $display("FAIL d23_ov: got %b want 1", b23.out_valid); else passed++;
        checks++; if (b23.res_out !== 46'h2AAA_AAAA_AAAA) $display("FAIL d23_res_out: got %h want 2aaaaaaaaaaa", b23.res_out); else passed++;
        ord23 = 1'b1;
        step();
        ord23 = 1'b0;
        checks++; if (b23.col_bus !== 529'h0) $display("FAIL d23_clear_bus: got %h want 0", b23.col_bus); else passed++;
        checks++; if (b23.out_valid !== 1'b0) $display("FAIL d23_consume_ov: got %b want 0", b23.out_valid); else passed++;
    endtask

    initial begin
        checks   = 0;
        passed   = 0;
        rst      = 1'b1;
        v4       = '0;
        ord4     = '0;
        for (int k = 0; k < 3; k++) begin
            b4[k] = '0;
            r4[k] = '0;
        end
        v23      = 1'b0;
        v23_bits = '0;
        r23      = '0;
        ord23    = 1'b0;
        all_ones = '1;
        t16      = '0;

        test_reset();
        test_fill_order();
        test_flow_control();
        test_latency();
        test_backpressure();
        test_no_clear();
        test_default_23();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cmp_column_loader.md
Name: cmp_column_loader

Overview:
- Parametrised serial-load harness that fills the per-column bit registers of a W_A x W_B partial-product compressor from one bit per column per beat.
- Presents the filled column bus to the compressor, waits a programmable compressor latency, then captures the COLS+1-bit result behind a valid/ready handshake.
- Next generation of the fixed 23x23 column shift register: generic widths, flow control, a latency counter and a result capture stage.
- Sits between the test/IO source and compressor, which is instantiated by the parent.

Parameters:
W_A, 23, multiplicand width (>=1)
W_B, 23, multiplier width (>=1)
PIPE_LAT, 0, compressor pipeline latency in cycles (0..255)
CLEAR_ON_DONE, 1, 1 = zero all column registers when a result is consumed

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  loader accepts a beat
in_bits  in  COLS  one new bit per column; bit i goes to column i
cols_valid  out  1  column bus complete and stable
col_bus  out  TOTAL  packed column registers; column i occupies [OFF(i)+H(i)-1 : OFF(i)]
res_in  in  COLS+1  compressor result
out_valid  out  1  captured result valid
out_ready  in  1  consumer takes result
res_out  out  COLS+1  captured result

Behaviour:
- Derived constants: COLS = W_A+W_B-1; H(i) = min(i+1, W_A, W_B, COLS-i); MAX_H = min(W_A, W_B); TOTAL = W_A*W_B; OFF(i) = sum of H(j) for j<i.
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all column registers 0, state LOAD, beat_cnt 0, wait_cnt 0, in_ready 1, cols_valid 0, out_valid 0, res_out 0.
  - rst has priority over every other event.
  - rst asserted mid-load or mid-wait aborts the operation; no partial result is emitted.
- State LOAD:
  - in_ready = 1.
  - Accepted beat (in_valid & in_ready): every column register shifts left by one with in_bits[i] entering bit 0. The bit at position H(i)-1 is dropped. Columns shift simultaneously.
  - beat_cnt increments on each accepted beat.
  - On the accept that makes beat_cnt reach MAX_H, go to EVAL next cycle and reset beat_cnt to 0.
  - Result: after MAX_H beats every column holds its last H(i) bits, oldest at the MSB.
  - Cycles without in_valid change nothing.
- State EVAL:
  - in_ready = 0, cols_valid = 1, col_bus frozen. in_valid is ignored.
  - wait_cnt starts at 0 on entry and increments each cycle.
  - On the cycle where wait_cnt == PIPE_LAT, res_in is registered into res_out and the state goes to DONE.
  - PIPE_LAT = 0 therefore captures in the first EVAL cycle, and out_valid rises 1 cycle after the final beat + 1.
- State DONE:
  - out_valid = 1; res_out is held stable; cols_valid stays 1 and col_bus stays frozen.
  - On out_valid & out_ready: next state LOAD, out_valid 0, cols_valid 0.
  - If CLEAR_ON_DONE = 1, zero all column registers in that same cycle. Otherwise keep them, so the next load shifts over the old content.
- Latency: final accepted beat edge → out_valid high after PIPE_LAT+2 edges (1 edge to enter EVAL, PIPE_LAT+1 edges to capture).
- Throughput: one result per MAX_H + PIPE_LAT + 2 cycles minimum. There is no overlap of loading and evaluation.
- Width rules:
  - res_out is exactly COLS+1 bits; there is no truncation.
  - Bits of in_bits are never dropped except by shift-out beyond H(i).

Decomposition:
- Package cmp_loader_pkg holds:
  - constant functions col_height(i, W_A, W_B) and col_offset(i, W_A, W_B);
  - the state enum {LOAD, EVAL, DONE};
  - a localparam helper for TOTAL.
- One sub-module, cmp_column_sreg #(H): a single-column variable-height shift register with shift enable and synchronous clear.
  - It is instantiated COLS times in a generate loop; the top holds the FSM and counters.

Test Plan:
- Reset: W_A=W_B=4 (COLS=7, heights 1,2,3,4,3,2,1, TOTAL=16, offsets 0,1,3,6,10,13,15). Hold rst 3 cycles mid-load → in_ready=1, cols_valid=0, out_valid=0, col_bus=16'h0000.
- Fill order: beats in_bits = 7'h7F, 0, 0, 0 with PIPE_LAT=0 → col3 = 4'b1000, col2 = 3'b000, col0 = 1'b0. cols_valid rises 1 cycle after the 4th beat; res_out = res_in sampled on that cycle.
- Flow control:
  - in_valid toggling 1,0,1,0,... → exactly 4 accepted beats before EVAL.
  - in_valid held high during EVAL/DONE → no shift, col_bus unchanged.
- Latency: PIPE_LAT=3, res_in driven 8'hA5 (zero-extended) only on the capture cycle → out_valid exactly 5 edges after the last beat, res_out = 8'hA5.
- Backpressure/clear:
  - out_ready low 10 cycles → res_out stable and out_valid held.
  - Then out_ready high → LOAD next cycle, col_bus=0 with CLEAR_ON_DONE=1.
  - With CLEAR_ON_DONE=0, col_bus is retained.
- Default 23x23: 23 beats of all-ones → every column register all-ones (col_bus = 529 ones), col22 height 23, col44 height 1.
